// File: rtl/ysyx_25070198_pkg.sv
// Shared types and constants for the multi-cycle load/store unit.
// Holds the FSM state encoding, access-size codes and the byte-lane mask helper.
package ysyx_25070198_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << off;
            SZ_H:    mask = 4'b0011 << off;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_25070198_lsu_align.sv
// Combinational data alignment for the LSU: store lane replication, write mask,
// misalignment detection, and load byte/half extraction with zero/sign extension.
module ysyx_25070198_lsu_align
    import ysyx_25070198_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic        ld_sext,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store side: replicate the right-justified data across every lane so any offset lines up.
    always_comb begin
        st_wdata   = 32'd0;
        st_wmask   = lane_mask(st_size, st_off);
        misaligned = 1'b1;
        case (st_size)
            SZ_B: begin
                st_wdata   = {4{st_data[7:0]}};
                misaligned = 1'b0;
            end
            SZ_H: begin
                st_wdata   = {2{st_data[15:0]}};
                misaligned = st_off[0];
            end
            SZ_W: begin
                st_wdata   = st_data;
                misaligned = (st_off != 2'd0);
            end
            default: begin
                st_wdata   = 32'd0;
                misaligned = 1'b1;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        shifted_s = ld_raw >> {ld_off, 3'b000};
        ld_data   = 32'd0;
        case (ld_size)
            SZ_B: begin
                if (ld_sext) begin
                    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end else begin
                    ld_data = {24'd0, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                if (ld_sext) begin
                    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end else begin
                    ld_data = {16'd0, shifted_s[15:0]};
                end
            end
            SZ_W:    ld_data = shifted_s;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_25070198_lsu.sv
// Multi-cycle load/store unit: accepts one EXU memory op, runs a SimpleBus-style
// request/response transaction and returns aligned load data with a one-cycle pulse.
module ysyx_25070198_lsu
    import ysyx_25070198_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wmask,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rerr
);

    lsu_state_t        state_r;
    logic              wen_r;
    logic [1:0]        size_r;
    logic              sext_r;
    logic [1:0]        off_r;
    logic              bus_valid_r;
    logic              bus_wen_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [3:0]        bus_wmask_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;

    logic [31:0]       st_wdata_s;
    logic [3:0]        st_wmask_s;
    logic              misaligned_s;
    logic [31:0]       ld_data_s;

    ysyx_25070198_lsu_align u_align (
        .st_size    (req_size),
        .st_off     (req_addr[1:0]),
        .st_data    (req_wdata),
        .st_wdata   (st_wdata_s),
        .st_wmask   (st_wmask_s),
        .misaligned (misaligned_s),
        .ld_size    (size_r),
        .ld_sext    (sext_r),
        .ld_off     (off_r),
        .ld_raw     (bus_rdata),
        .ld_data    (ld_data_s)
    );

    assign req_ready  = (state_r == IDLE);
    assign bus_valid  = bus_valid_r;
    assign bus_wen    = bus_wen_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign bus_wmask  = bus_wmask_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Transaction FSM; bus request fields stay frozen from handshake until bus_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            wen_r        <= 1'b0;
            size_r       <= 2'd0;
            sext_r       <= 1'b0;
            off_r        <= 2'd0;
            bus_valid_r  <= 1'b0;
            bus_wen_r    <= 1'b0;
            bus_addr_r   <= '0;
            bus_wdata_r  <= '0;
            bus_wmask_r  <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        wen_r  <= req_wen;
                        size_r <= req_size;
                        sext_r <= req_sext;
                        off_r  <= req_addr[1:0];
                        if (misaligned_s) begin
                            // Illegal or misaligned ops never reach the bus.
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                        end else begin
                            state_r     <= REQ;
                            bus_valid_r <= 1'b1;
                            bus_wen_r   <= req_wen;
                            bus_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_wdata_r <= req_wen ? st_wdata_s : 32'd0;
                            bus_wmask_r <= req_wen ? st_wmask_s : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid_r <= 1'b0;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= bus_rerr;
                        resp_rdata_r <= (bus_rerr || wen_r) ? 32'd0 : ld_data_s;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                end
                default: begin
                    state_r      <= IDLE;
                    bus_valid_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25070198_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus randomized ops checked
// against an arithmetic model of lane placement and load extension.
module tb_ysyx_25070198_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_rerr;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    ysyx_25070198_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_rerr   (bus_rerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic illegal(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || ((int'(off) % nbytes(size)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sext,
                                               input logic [1:0] off, input logic [31:0] raw);
        longint v;
        longint span;
        span = longint'(1) << (8 * nbytes(size));
        v    = raw;
        v    = (v >> (8 * int'(off))) % span;
        if (sext && nbytes(size) < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(off) && k < int'(off) + nbytes(size)) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % nbytes(size)) +: 8];
        return w;
    endfunction

    // One complete operation; caller is #1 after a rising edge with the DUT idle.
    task automatic do_op(input logic wen, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic rerr,
                         input int rdy_dly, input int rv_dly);
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_addr = {addr[31:2], 2'b00};
        if (illegal(size, addr[1:0])) begin
            chk("ill_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("ill_resp_err", {31'd0, resp_err}, 32'd1);
            chk("ill_resp_rdata", resp_rdata, 32'd0);
            chk("ill_bus_valid", {31'd0, bus_valid}, 32'd0);
            chk("ill_req_ready", {31'd0, req_ready}, 32'd0);
        end else begin
            for (int d = 0; d <= rdy_dly; d++) begin
                chk("bus_valid", {31'd0, bus_valid}, 32'd1);
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_wen", {31'd0, bus_wen}, {31'd0, wen});
                chk("bus_wmask", {28'd0, bus_wmask}, wen ? {28'd0, model_mask(size, addr[1:0])} : 32'd0);
                if (wen) chk("bus_wdata", bus_wdata, model_wdata(size, wdata));
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                bus_ready = (d == rdy_dly);
                @(posedge clk); #1;
            end
            bus_ready = 1'b0;
            for (int d = 0; d <= rv_dly; d++) begin
                chk("wait_bus_valid", {31'd0, bus_valid}, 32'd0);
                chk("wait_resp_valid", {31'd0, resp_valid}, 32'd0);
                bus_rvalid = (d == rv_dly);
                bus_rdata  = rdata;
                bus_rerr   = rerr;
                @(posedge clk); #1;
            end
            bus_rvalid = 1'b0;
            bus_rerr   = 1'b0;
            exp_rd = (rerr || wen) ? 32'd0 : model_load(size, sext, addr[1:0], rdata);
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_err", {31'd0, resp_err}, {31'd0, rerr});
            chk("resp_rdata", resp_rdata, exp_rd);
        end
        @(posedge clk); #1;
        chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({pfx, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
        chk({pfx, "_bus_wen"}, {31'd0, bus_wen}, 32'd0);
        chk({pfx, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({pfx, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({pfx, "_bus_addr"}, bus_addr, 32'd0);
        chk({pfx, "_bus_wdata"}, bus_wdata, 32'd0);
        chk({pfx, "_bus_wmask"}, {28'd0, bus_wmask}, 32'd0);
        chk({pfx, "_resp_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_rerr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        do_op(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB, 32'd0, 1'b0, 0, 0);
        do_op(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'd0, 32'h8001_1234, 1'b0, 0, 0);
        do_op(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'd0, 32'h8001_1234, 1'b0, 0, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'd0, 32'd0, 1'b0, 0, 0);
        do_op(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 5, 2);
        do_op(1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 0);
        do_op(1'b1, 2'd3, 1'b0, 32'h8000_0000, 32'h1234_5678, 32'd0, 1'b0, 0, 0);
        do_op(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0, 32'h80FF_7F00, 1'b0, 1, 1);

        // Reset while waiting for the response, followed by a stray late response.
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0010;
        @(posedge clk); #1;
        req_valid = 1'b0; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        chk("mid_wait_bus_valid", {31'd0, bus_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk_reset_outputs("stray");
        do_op(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'd0, 32'hCAFE_F00D, 1'b0, 0, 0);

        // Randomized ops.
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h8000_0000 | ($urandom & 32'h0000_0FFF), $urandom, $urandom,
                  1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ysyx_25070198_lsu.md
# ysyx_25070198_lsu

Multi-cycle load/store unit that sits directly downstream of the EXU memory-request outputs and upstream of the data memory bus. It accepts one byte/half/word load or store per handshake and aligns store data into byte lanes with a write mask. It runs a valid/ready request plus response transaction on a SimpleBus-style port, then returns extracted, zero- or sign-extended load data with a one-cycle completion pulse. This replaces the fixed one-cycle registered memory path so the core can tolerate variable-latency memory.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width; fixed at 32, 4 byte lanes
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  EXU presents a memory op
- req_ready  out  1  LSU idle; handshake when req_valid && req_ready
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_sext  in  1  sign-extend load result (ignored for word/store)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  misaligned, illegal size, or bus error; valid with resp_valid
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts request
- bus_wen  out  1  request is a write
- bus_addr  out  ADDR_W  word-aligned address ({req_addr[31:2],2'b0})
- bus_wdata  out  32  lane-replicated store data
- bus_wmask  out  4  byte-lane write mask; 0 for reads
- bus_rvalid  in  1  response (read data or write ack)
- bus_rdata  in  32  raw read word
- bus_rerr  in  1  response error, qualified by bus_rvalid

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On handshake, latch op, size, sext, offset=addr[1:0], aligned addr, shifted wdata, mask. Misaligned (half with off[0]=1, word with off!=0) or size 3 -> RESP with err=1, no bus transaction; else -> REQ.
- REQ: bus_valid=1, bus_* held stable until bus_ready. On bus_ready -> WAIT.
- WAIT: on bus_rvalid latch rdata/err -> RESP. bus_rvalid in any other state is ignored.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=0 here (no same-cycle re-accept).
- Store lanes: byte wdata={4{d[7:0]}}, wmask=4'b0001<<off; half wdata={2{d[15:0]}}, wmask=4'b0011<<off; word wdata=d, wmask=4'b1111.
- Load extract: w = bus_rdata >> (8*off); byte -> w[7:0], half -> w[15:0], zero-extended, or sign-extended when req_sext=1. Word -> w.
- Error response: resp_rdata=0, resp_err=1. Stores: resp_rdata=0.

## Timing
- Reset (rst=0, async): state IDLE; bus_valid, bus_wen, resp_valid, resp_err = 0; bus_addr, bus_wdata, bus_wmask, resp_rdata = 0; req_ready=1.
- Minimum latency: handshake in cycle 0, bus_valid in cycle 1, bus_ready in cycle 1, bus_rvalid in cycle 2, resp_valid in cycle 3.
- Each bus_ready stall cycle and each rvalid wait cycle adds one cycle.
- Misaligned/illegal path: handshake in cycle 0, resp_valid in cycle 1.
- Reset asserted mid-operation aborts without resp_valid. A late bus_rvalid after reset release is ignored because the state is IDLE.
- One outstanding transaction max. No request pipelining.
- All outputs are registered except req_ready, which is decoded from state.

## Structure
- Package ysyx_25070198_pkg:
  - lsu_state_t enum: IDLE/REQ/WAIT/RESP.
  - Size constants: SZ_B=0, SZ_H=1, SZ_W=2.
- Sub-module ysyx_25070198_lsu_align, purely combinational:
  - Store lane replication, wmask generation, and misalignment detect.
  - Load shift and extension.
- The FSM and registers stay in the top LSU.

## Test plan
- Store byte addr=0x80000003 data=0x000000AB, bus_ready immediate, rvalid next cycle -> bus_addr=0x80000000, wdata=0xABABABAB, wmask=4'b1000; resp_valid 3 cycles after handshake, resp_err=0.
- Load half sext addr=0x80000002, bus_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001. Same with sext=0 -> 0x00008001.
- Load word addr=0x80000001 -> resp_valid+resp_err one cycle after handshake, resp_rdata=0, bus_valid never asserted.
- bus_ready held low 5 cycles -> bus_valid, bus_addr, bus_wdata, bus_wmask stable throughout, req_ready=0; resp_valid after the rvalid.
- Load byte addr=0x80000001, bus_rerr=1 with rvalid -> resp_err=1, resp_rdata=0.
- rst pulled low while in WAIT, then released, then a stray bus_rvalid -> no resp_valid; all outputs at reset values; next request completes normally.
